// File: rtl/spi_storage_responder.sv
// SPI mode-0 serial-flash responder over an internal byte array, with a parallel backdoor port.
// Supports READ (03), PAGE PROGRAM (02), READ STATUS (05), WRITE ENABLE (06) and WRITE DISABLE (04).
module spi_storage_responder #(
  parameter int unsigned MEM_BYTES  = 8192,
  parameter int unsigned PAGE_BYTES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_cs_n,
  input  logic                         spi_sck,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_BYTES)-1:0] bd_addr,
  input  logic [7:0]                   bd_wdata,
  output logic [7:0]                   bd_rdata,
  output logic                         cmd_err
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  // Shift register only needs to hold what the longer of opcode/address decode consumes.
  localparam int unsigned SW = (AW - 1 > 7) ? AW - 1 : 7;
  localparam logic [AW-1:0] PageMask = AW'(PAGE_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StRead, StProg, StStatus, StIgnore
  } state_e;

  logic [7:0] mem [MEM_BYTES];

  logic [1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic       cs_prev_q, sck_prev_q;
  logic       cs_n_s, sck_s, mosi_s;
  logic       cs_fall, cs_rise, sck_rise, sck_fall;

  state_e        state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          is_read_q, is_read_d;
  logic          wel_q, wel_d;
  logic [7:0]    tx_q, tx_d;
  logic [2:0]    tx_cnt_q, tx_cnt_d;
  logic          miso_q, miso_d;
  logic          cmd_err_q, cmd_err_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_rd_q;
  logic [7:0]    bd_rdata_q;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_src;
  logic [AW-1:0] addr_inc;

  // Synchronizers clear to 0 so a cs_n held low across reset release never looks like a fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      sck_sync_q  <= {sck_sync_q[0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      cs_prev_q   <= cs_sync_q[1];
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  assign cs_n_s   = cs_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign cs_fall  = cs_prev_q & ~cs_n_s;
  assign cs_rise  = ~cs_prev_q & cs_n_s;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    is_read_d = is_read_q;
    wel_d     = wel_q;
    tx_d      = tx_q;
    tx_cnt_d  = tx_cnt_q;
    miso_d    = miso_q;
    cmd_err_d = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rx_byte   = {shift_q[6:0], mosi_s};
    addr_inc  = addr_q + 1'b1;
    tx_src    = (state_q == StRead) ? mem_rd_q : {6'b0, wel_q, 1'b0};

    if (cs_rise) begin
      state_d = StIdle;
      miso_d  = 1'b0;
      if (state_q == StProg) wel_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
            miso_d    = 1'b0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            shift_d   = {shift_q[SW-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              tx_cnt_d  = '0;
              case (rx_byte)
                8'h03: begin state_d = StAddr; is_read_d = 1'b1; end
                8'h02: begin state_d = StAddr; is_read_d = 1'b0; end
                8'h05: state_d = StStatus;
                8'h06: begin state_d = StIgnore; wel_d = 1'b1; end
                8'h04: begin state_d = StIgnore; wel_d = 1'b0; end
                default: begin state_d = StIgnore; cmd_err_d = 1'b1; end
              endcase
            end
          end
        end
        StAddr: begin
          if (sck_rise) begin
            shift_d   = {shift_q[SW-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              addr_d    = {shift_q[AW-2:0], mosi_s};
              if (is_read_q)  state_d = StRead;
              else if (wel_q) state_d = StProg;
              else            state_d = StIgnore;
            end
          end
        end
        StRead: begin
          // Advancing addr here lets mem_rd_q settle before the next falling edge.
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q[2:0] == 3'd7) begin
              bit_cnt_d = '0;
              addr_d    = addr_inc;
            end
          end
        end
        StProg: begin
          if (sck_rise) begin
            shift_d   = {shift_q[SW-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = rx_byte;
              addr_d    = (addr_q & ~PageMask) | (addr_inc & PageMask);
            end
          end
        end
        default: ;
      endcase

      if (sck_fall && (state_q == StRead || state_q == StStatus)) begin
        tx_cnt_d = tx_cnt_q + 3'd1;
        if (tx_cnt_q == 3'd0) begin
          miso_d = tx_src[7];
          tx_d   = {tx_src[6:0], 1'b0};
        end else begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      is_read_q  <= 1'b0;
      wel_q      <= 1'b0;
      tx_q       <= '0;
      tx_cnt_q   <= '0;
      miso_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      bd_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      is_read_q  <= is_read_d;
      wel_q      <= wel_d;
      tx_q       <= tx_d;
      tx_cnt_q   <= tx_cnt_d;
      miso_q     <= miso_d;
      cmd_err_q  <= cmd_err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      bd_rdata_q <= mem[bd_addr];
    end
  end

  // SPI commit is written last so it wins a same-address collision with the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we)   mem[bd_addr]   <= bd_wdata;
    if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
    mem_rd_q <= mem[addr_q];
  end

  assign spi_miso = miso_q;
  assign bd_rdata = bd_rdata_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_storage_responder.sv
// Directed bench for spi_storage_responder: bit-banged SPI master plus backdoor preload/inspect.
module tb_spi_storage_responder;

  localparam int unsigned H = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs_n, spi_sck, spi_mosi, spi_miso;
  logic        bd_we;
  logic [12:0] bd_addr;
  logic [7:0]  bd_wdata, bd_rdata;
  logic        cmd_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned err_pulses = 0;

  always #5 clk = ~clk;

  spi_storage_responder #(.MEM_BYTES(8192), .PAGE_BYTES(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .bd_rdata (bd_rdata),
    .cmd_err  (cmd_err)
  );

  always @(posedge clk) if (cmd_err === 1'b1) err_pulses <= err_pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = tx[i];
      wait_clk(H);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      wait_clk(H);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    spi_cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_cmd4(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] r;
    spi_byte(op, r);
    spi_byte(a[23:16], r);
    spi_byte(a[15:8], r);
    spi_byte(a[7:0], r);
  endtask

  task automatic single_op(input logic [7:0] op);
    logic [7:0] r;
    cs_low();
    spi_byte(op, r);
    cs_high();
  endtask

  task automatic read_status(output logic [7:0] st);
    logic [7:0] r;
    cs_low();
    spi_byte(8'h05, r);
    spi_byte(8'h00, st);
    cs_high();
  endtask

  task automatic bd_write(input logic [12:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_addr = a; bd_wdata = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic bd_read(input logic [12:0] a, output logic [7:0] d);
    @(negedge clk);
    bd_addr = a;
    @(negedge clk);
    d = bd_rdata;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] exp4 [4];
    int unsigned pulses0;
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;

    rst = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    wait_clk(3);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_bd_rdata", 32'(bd_rdata), 32'h0);
    check("rst_cmd_err", 32'(cmd_err), 32'h0);
    rst = 1'b1;
    wait_clk(5);

    // Backdoor preload then 4-byte SPI READ.
    for (int i = 0; i < 4; i++) bd_write(13'h100 + 13'(i), exp4[i]);
    cs_low();
    send_cmd4(8'h03, 24'h000100);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, r);
      check($sformatf("read_0x10%0d", i), 32'(r), 32'(exp4[i]));
    end
    cs_high();

    // READ wraps from the top of the array back to 0.
    bd_write(13'h1FFF, 8'h5A);
    bd_write(13'h0000, 8'hA5);
    cs_low();
    send_cmd4(8'h03, 24'h001FFF);
    spi_byte(8'h00, r);
    check("read_top", 32'(r), 32'h5A);
    spi_byte(8'h00, r);
    check("read_wrap", 32'(r), 32'hA5);
    cs_high();

    // WREN, status, page program with page wrap, status after.
    single_op(8'h06);
    read_status(r);
    check("status_wel", 32'(r), 32'h02);
    cs_low();
    send_cmd4(8'h02, 24'h0002FE);
    spi_byte(8'hAA, r);
    spi_byte(8'hBB, r);
    spi_byte(8'hCC, r);
    cs_high();
    bd_read(13'h2FE, r); check("prog_2fe", 32'(r), 32'hAA);
    bd_read(13'h2FF, r); check("prog_2ff", 32'(r), 32'hBB);
    bd_read(13'h200, r); check("prog_200_wrap", 32'(r), 32'hCC);
    read_status(r);
    check("status_cleared", 32'(r), 32'h00);

    // PROG without WREN leaves memory alone.
    bd_write(13'h300, 8'h77);
    cs_low();
    send_cmd4(8'h02, 24'h000300);
    spi_byte(8'h55, r);
    cs_high();
    bd_read(13'h300, r);
    check("prog_no_wel", 32'(r), 32'h77);

    // Unsupported opcode.
    pulses0 = err_pulses;
    cs_low();
    spi_byte(8'h9F, r);
    spi_byte(8'h00, r);
    check("bad_op_miso", 32'(r), 32'h00);
    cs_high();
    check("bad_op_pulses", err_pulses - pulses0, 32'd1);

    // cs_n raised partway through the second program byte.
    bd_write(13'h400, 8'h00);
    bd_write(13'h401, 8'h11);
    single_op(8'h06);
    cs_low();
    send_cmd4(8'h02, 24'h000400);
    spi_byte(8'hDE, r);
    spi_bits(8'hAD, 5, r);
    cs_high();
    bd_read(13'h400, r); check("partial_first", 32'(r), 32'hDE);
    bd_read(13'h401, r); check("partial_dropped", 32'(r), 32'h11);
    read_status(r);
    check("partial_wel_clr", 32'(r), 32'h00);
    cs_low();
    send_cmd4(8'h03, 24'h000400);
    spi_byte(8'h00, r);
    check("partial_readback", 32'(r), 32'hDE);
    cs_high();

    // Reset mid-READ with cs_n held low.
    cs_low();
    send_cmd4(8'h03, 24'h000100);
    spi_byte(8'h00, r);
    check("pre_rst_read", 32'(r), 32'h11);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(3);
    check("mid_rst_miso", 32'(spi_miso), 32'h0);
    rst = 1'b1;
    wait_clk(4);
    spi_byte(8'h00, r);
    check("post_rst_silent", 32'(r), 32'h00);
    send_cmd4(8'h03, 24'h000100);
    spi_byte(8'h00, r);
    check("post_rst_no_cmd", 32'(r), 32'h00);
    cs_high();
    cs_low();
    send_cmd4(8'h03, 24'h000101);
    spi_byte(8'h00, r);
    check("fresh_read", 32'(r), 32'h22);
    cs_high();
    bd_read(13'h103, r);
    check("array_kept", 32'(r), 32'h44);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
